// File: rtl/cpu_pkg.sv
// Shared CPU-wide definitions: default bus widths, the memory arbiter state
// encoding and a small request-qualification helper.
package cpu_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int TIMEOUT_DEF    = 15;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_BUSY  = 2'd1,
        FETCH_BUSY = 2'd2
    } arb_state_e;

    // A port only competes for the memory while its previous completion is not being presented.
    function automatic logic port_pending(input logic req, input logic ready);
        return req & ~ready;
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Busy-cycle counter for the memory arbiter; expired marks the last cycle in
// which a missing mem_ack is still tolerated.
module arb_timeout_cnt
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    // Count busy cycles; holds at the last value because the arbiter leaves the busy state there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (enable && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the
// MEM-stage data port; data wins ties, each access is bounded by a timeout.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  dm_read,
    input  logic                  dm_write,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  stall_if,
    output logic                  stall_mem,
    output logic                  bus_err,
    output logic                  rw_conflict
);

    arb_state_e            state_r, state_nxt_s;
    logic                  mem_req_r, mem_req_nxt_s;
    logic                  mem_we_r, mem_we_nxt_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_WIDTH-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic [DATA_WIDTH-1:0] if_rdata_r, if_rdata_nxt_s;
    logic [DATA_WIDTH-1:0] dm_rdata_r, dm_rdata_nxt_s;
    logic                  if_ready_r, if_ready_nxt_s;
    logic                  dm_ready_r, dm_ready_nxt_s;
    logic                  bus_err_r, bus_err_nxt_s;
    logic                  rw_conflict_r, rw_conflict_nxt_s;

    logic data_pend_s;
    logic fetch_pend_s;
    logic cnt_clear_s;
    logic cnt_enable_s;
    logic expired_s;

    assign data_pend_s  = port_pending(dm_read | dm_write, dm_ready_r);
    assign fetch_pend_s = port_pending(if_req, if_ready_r);
    assign cnt_clear_s  = (state_r == IDLE);
    assign cnt_enable_s = (state_r != IDLE) & ~mem_ack;

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear_s),
        .enable  (cnt_enable_s),
        .expired (expired_s)
    );

    // Next-state and next registered-output logic for the arbitration FSM.
    always_comb begin
        state_nxt_s       = state_r;
        mem_req_nxt_s     = mem_req_r;
        mem_we_nxt_s      = mem_we_r;
        mem_addr_nxt_s    = mem_addr_r;
        mem_wdata_nxt_s   = mem_wdata_r;
        if_rdata_nxt_s    = if_rdata_r;
        dm_rdata_nxt_s    = dm_rdata_r;
        if_ready_nxt_s    = 1'b0;
        dm_ready_nxt_s    = 1'b0;
        bus_err_nxt_s     = 1'b0;
        rw_conflict_nxt_s = rw_conflict_r | (dm_read & dm_write);
        case (state_r)
            IDLE: begin
                if (data_pend_s) begin
                    // A simultaneous load and store is treated as a store.
                    state_nxt_s     = DATA_BUSY;
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = dm_write;
                    mem_addr_nxt_s  = dm_addr;
                    mem_wdata_nxt_s = dm_write ? dm_wdata : '0;
                end else if (fetch_pend_s) begin
                    state_nxt_s     = FETCH_BUSY;
                    mem_req_nxt_s   = 1'b1;
                    mem_we_nxt_s    = 1'b0;
                    mem_addr_nxt_s  = if_addr;
                    mem_wdata_nxt_s = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DATA_BUSY: begin
                if (mem_ack) begin
                    state_nxt_s    = IDLE;
                    mem_req_nxt_s  = 1'b0;
                    mem_we_nxt_s   = 1'b0;
                    dm_ready_nxt_s = 1'b1;
                    if (mem_we_r) begin
                        dm_rdata_nxt_s = dm_rdata_r;
                    end else begin
                        dm_rdata_nxt_s = mem_rdata;
                    end
                end else if (expired_s) begin
                    state_nxt_s    = IDLE;
                    mem_req_nxt_s  = 1'b0;
                    mem_we_nxt_s   = 1'b0;
                    dm_ready_nxt_s = 1'b1;
                    bus_err_nxt_s  = 1'b1;
                    if (mem_we_r) begin
                        dm_rdata_nxt_s = dm_rdata_r;
                    end else begin
                        dm_rdata_nxt_s = '0;
                    end
                end else begin
                    state_nxt_s = DATA_BUSY;
                end
            end
            FETCH_BUSY: begin
                if (mem_ack) begin
                    state_nxt_s    = IDLE;
                    mem_req_nxt_s  = 1'b0;
                    mem_we_nxt_s   = 1'b0;
                    if_ready_nxt_s = 1'b1;
                    if_rdata_nxt_s = mem_rdata;
                end else if (expired_s) begin
                    state_nxt_s    = IDLE;
                    mem_req_nxt_s  = 1'b0;
                    mem_we_nxt_s   = 1'b0;
                    if_ready_nxt_s = 1'b1;
                    bus_err_nxt_s  = 1'b1;
                    if_rdata_nxt_s = '0;
                end else begin
                    state_nxt_s = FETCH_BUSY;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                mem_req_nxt_s = 1'b0;
                mem_we_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
            if_rdata_r    <= '0;
            dm_rdata_r    <= '0;
            if_ready_r    <= 1'b0;
            dm_ready_r    <= 1'b0;
            bus_err_r     <= 1'b0;
            rw_conflict_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            mem_req_r     <= mem_req_nxt_s;
            mem_we_r      <= mem_we_nxt_s;
            mem_addr_r    <= mem_addr_nxt_s;
            mem_wdata_r   <= mem_wdata_nxt_s;
            if_rdata_r    <= if_rdata_nxt_s;
            dm_rdata_r    <= dm_rdata_nxt_s;
            if_ready_r    <= if_ready_nxt_s;
            dm_ready_r    <= dm_ready_nxt_s;
            bus_err_r     <= bus_err_nxt_s;
            rw_conflict_r <= rw_conflict_nxt_s;
        end
    end

    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign if_rdata    = if_rdata_r;
    assign dm_rdata    = dm_rdata_r;
    assign if_ready    = if_ready_r;
    assign dm_ready    = dm_ready_r;
    assign bus_err     = bus_err_r;
    assign rw_conflict = rw_conflict_r;
    assign stall_if    = fetch_pend_s;
    assign stall_mem   = data_pend_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by randomized
// fetch/data traffic against a behavioural memory with per-address latency.
module tb_mem_arbiter;

    localparam int TO = 15;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [11:0] if_addr = 12'h000;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [11:0] dm_addr = 12'h000;
    logic [15:0] dm_wdata = 16'h0000;
    logic [15:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;
    logic        rw_conflict;

    // Environment: memory contents seen by the DUT, model copy, latency per address (0 = never acks).
    logic [15:0] mem_arr [0:4095];
    logic [15:0] exp_mem [0:4095];
    int          lat_tab [0:4095];
    exp_t        if_q[$];
    exp_t        dm_q[$];
    logic [15:0] last_dm = 16'h0000;
    logic        conflict_exp = 1'b0;
    bit          stray_en = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    int          bcnt = 0;
    logic [11:0] cap_addr;
    logic        cap_we;
    logic [15:0] cap_wdata;

    mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err), .rw_conflict(rw_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [11:0] a);
        exp_t e;
        e.err  = (lat_tab[a] == 0);
        e.data = e.err ? 16'h0000 : exp_mem[a];
        if_q.push_back(e);
    endtask

    task automatic push_data(input logic rd, input logic wr, input logic [11:0] a, input logic [15:0] wd);
        exp_t e;
        e.err = (lat_tab[a] == 0);
        if (wr) begin
            e.data = last_dm;
            if (!e.err) exp_mem[a] = wd;
        end else begin
            e.data  = e.err ? 16'h0000 : exp_mem[a];
            last_dm = e.data;
        end
        if (rd && wr) conflict_exp = 1'b1;
        dm_q.push_back(e);
    endtask

    // Memory responder: acks after the per-address latency and checks the request stays stable.
    always @(negedge clk) begin
        if (reset) begin
            bcnt    = 0;
            mem_ack = 1'b0;
        end else if (mem_req) begin
            bcnt = bcnt + 1;
            if (bcnt == 1) begin
                cap_addr  = mem_addr;
                cap_we    = mem_we;
                cap_wdata = mem_wdata;
            end else begin
                chk("mem_addr_hold", {20'h0, mem_addr}, {20'h0, cap_addr});
                chk("mem_we_hold", {31'h0, mem_we}, {31'h0, cap_we});
                chk("mem_wdata_hold", {16'h0, mem_wdata}, {16'h0, cap_wdata});
            end
            if (lat_tab[mem_addr] != 0 && bcnt == lat_tab[mem_addr]) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_arr[mem_addr] = mem_wdata;
                    mem_rdata = 16'($urandom);
                end else begin
                    mem_rdata = mem_arr[mem_addr];
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end else begin
            bcnt = 0;
            if (stray_en && $urandom_range(0, 3) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'($urandom);
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // Monitor: every ready pulse pops and checks one expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (if_ready) begin
                if (if_q.size() == 0) note_fail("if_ready_unexpected");
                else begin
                    e = if_q.pop_front();
                    chk("if_rdata", {16'h0, if_rdata}, {16'h0, e.data});
                    chk("if_bus_err", {31'h0, bus_err}, {31'h0, e.err});
                end
            end
            if (dm_ready) begin
                if (dm_q.size() == 0) note_fail("dm_ready_unexpected");
                else begin
                    e = dm_q.pop_front();
                    chk("dm_rdata", {16'h0, dm_rdata}, {16'h0, e.data});
                    chk("dm_bus_err", {31'h0, bus_err}, {31'h0, e.err});
                end
            end
            if (!if_ready && !dm_ready) chk("bus_err_quiet", {31'h0, bus_err}, 32'h0);
        end
    end

    task automatic wait_fetch();
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (if_ready) seen = 1'b1;
            else chk("stall_if_wait", {31'h0, stall_if}, 32'h1);
        end
        if (!seen) note_fail("if_ready_timeout");
        else chk("stall_if_done", {31'h0, stall_if}, 32'h0);
        cyc_start();
        if_req = 1'b0;
    endtask

    task automatic wait_data();
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (dm_ready) seen = 1'b1;
            else chk("stall_mem_wait", {31'h0, stall_mem}, 32'h1);
        end
        if (!seen) note_fail("dm_ready_timeout");
        else chk("stall_mem_done", {31'h0, stall_mem}, 32'h0);
        cyc_start();
        dm_read  = 1'b0;
        dm_write = 1'b0;
    endtask

    // Runs a single data access with a fixed latency and checks its timing cycle by cycle.
    task automatic timed_read(input logic [11:0] a, input int lat, input string tag);
        int done_c;
        lat_tab[a] = lat;
        done_c = (lat == 0) ? TO + 1 : lat + 1;
        push_data(1'b1, 1'b0, a, 16'h0000);
        dm_addr = a;
        dm_read = 1'b1;
        for (int c = 0; c <= done_c + 1; c++) begin
            @(negedge clk);
            chk({tag, "_mem_req"}, {31'h0, mem_req}, {31'h0, (c >= 1 && c < done_c) ? 1'b1 : 1'b0});
            chk({tag, "_dm_ready"}, {31'h0, dm_ready}, {31'h0, (c == done_c) ? 1'b1 : 1'b0});
            chk({tag, "_bus_err"}, {31'h0, bus_err}, {31'h0, (c == done_c && lat == 0) ? 1'b1 : 1'b0});
            cyc_start();
            if (c == done_c) dm_read = 1'b0;
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            mem_arr[a] = 16'(a * 37) ^ 16'h5A5A;
            exp_mem[a] = mem_arr[a];
            lat_tab[a] = 1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_if_ready", {31'h0, if_ready}, 32'h0);
        chk("rst_dm_ready", {31'h0, dm_ready}, 32'h0);
        chk("rst_rw_conflict", {31'h0, rw_conflict}, 32'h0);
        reset = 1'b0;

        // Fetch only, single-cycle memory.
        cyc_start();
        mem_arr[12'h010] = 16'hBEEF;
        exp_mem[12'h010] = 16'hBEEF;
        lat_tab[12'h010] = 1;
        push_fetch(12'h010);
        if_addr = 12'h010;
        if_req  = 1'b1;
        @(negedge clk);
        chk("f_c0_stall_if", {31'h0, stall_if}, 32'h1);
        chk("f_c0_mem_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        chk("f_c1_mem_req", {31'h0, mem_req}, 32'h1);
        chk("f_c1_mem_addr", {20'h0, mem_addr}, 32'h010);
        chk("f_c1_stall_if", {31'h0, stall_if}, 32'h1);
        @(negedge clk);
        chk("f_c2_if_ready", {31'h0, if_ready}, 32'h1);
        chk("f_c2_if_rdata", {16'h0, if_rdata}, 32'hBEEF);
        chk("f_c2_stall_if", {31'h0, stall_if}, 32'h0);
        cyc_start();
        if_req = 1'b0;
        @(negedge clk);
        chk("f_c3_no_reissue", {31'h0, mem_req}, 32'h0);
        cyc_start();

        // Contention: data port wins, fetch follows.
        lat_tab[12'h020] = 2;
        lat_tab[12'h100] = 2;
        push_data(1'b1, 1'b0, 12'h020, 16'h0000);
        push_fetch(12'h100);
        dm_addr = 12'h020;
        dm_read = 1'b1;
        if_addr = 12'h100;
        if_req  = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            chk("ct_stall_if", {31'h0, stall_if}, {31'h0, (c <= 5) ? 1'b1 : 1'b0});
            chk("ct_stall_mem", {31'h0, stall_mem}, {31'h0, (c <= 2) ? 1'b1 : 1'b0});
            chk("ct_mem_req", {31'h0, mem_req}, {31'h0, (c == 1 || c == 2 || c == 4 || c == 5) ? 1'b1 : 1'b0});
            if (c == 1) chk("ct_addr_data", {20'h0, mem_addr}, 32'h020);
            if (c == 4) chk("ct_addr_fetch", {20'h0, mem_addr}, 32'h100);
            chk("ct_dm_ready", {31'h0, dm_ready}, {31'h0, (c == 3) ? 1'b1 : 1'b0});
            chk("ct_if_ready", {31'h0, if_ready}, {31'h0, (c == 6) ? 1'b1 : 1'b0});
            cyc_start();
            if (c == 3) dm_read = 1'b0;
            if (c == 6) if_req = 1'b0;
        end

        // Store with three-cycle latency.
        lat_tab[12'h034] = 3;
        push_data(1'b0, 1'b1, 12'h034, 16'h1234);
        dm_addr  = 12'h034;
        dm_wdata = 16'h1234;
        dm_write = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                chk("st_mem_we", {31'h0, mem_we}, 32'h1);
                chk("st_mem_addr", {20'h0, mem_addr}, 32'h034);
                chk("st_mem_wdata", {16'h0, mem_wdata}, 32'h1234);
            end
            chk("st_dm_ready", {31'h0, dm_ready}, {31'h0, (c == 4) ? 1'b1 : 1'b0});
            cyc_start();
            if (c == 4) dm_write = 1'b0;
        end
        chk("st_mem_written", {16'h0, mem_arr[12'h034]}, 32'h1234);

        timed_read(12'h040, 0, "to");
        timed_read(12'h042, TO, "last");

        // Reset in the middle of a fetch after setting the conflict flag.
        lat_tab[12'h050] = 1;
        push_data(1'b1, 1'b1, 12'h050, 16'h7777);
        dm_addr  = 12'h050;
        dm_wdata = 16'h7777;
        dm_read  = 1'b1;
        dm_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("cf_mem_we", {31'h0, mem_we}, 32'h1);
        wait_data();
        chk("cf_rw_conflict", {31'h0, rw_conflict}, 32'h1);
        lat_tab[12'h060] = 0;
        push_fetch(12'h060);
        if_addr = 12'h060;
        if_req  = 1'b1;
        repeat (3) cyc_start();
        chk("rs_busy_before", {31'h0, mem_req}, 32'h1);
        reset = 1'b1;
        if_q.delete();
        last_dm      = 16'h0000;
        conflict_exp = 1'b0;
        #1;
        chk("rs_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rs_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rs_mem_addr", {20'h0, mem_addr}, 32'h0);
        chk("rs_mem_wdata", {16'h0, mem_wdata}, 32'h0);
        chk("rs_if_rdata", {16'h0, if_rdata}, 32'h0);
        chk("rs_dm_rdata", {16'h0, dm_rdata}, 32'h0);
        chk("rs_if_ready", {31'h0, if_ready}, 32'h0);
        chk("rs_dm_ready", {31'h0, dm_ready}, 32'h0);
        chk("rs_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rs_rw_conflict", {31'h0, rw_conflict}, 32'h0);
        chk("rs_stall_if", {31'h0, stall_if}, 32'h1);
        cyc_start();
        if_req = 1'b0;
        cyc_start();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rs_after_if_ready", {31'h0, if_ready}, 32'h0);
            chk("rs_after_mem_req", {31'h0, mem_req}, 32'h0);
            chk("rs_after_conflict", {31'h0, rw_conflict}, 32'h0);
        end
        cyc_start();

        // Randomized concurrent traffic with stray idle acks.
        for (int a = 12'h100; a < 12'h300; a++) lat_tab[a] = $urandom_range(0, TO);
        stray_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [11:0] fa;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    fa = 12'h100 + 12'($urandom_range(0, 255));
                    push_fetch(fa);
                    if_addr = fa;
                    if_req  = 1'b1;
                    wait_fetch();
                end
            end
            begin
                for (int j = 0; j < 30; j++) begin
                    logic [11:0] da;
                    logic [15:0] wd;
                    int          kind;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    da   = 12'h200 + 12'($urandom_range(0, 255));
                    wd   = 16'($urandom);
                    kind = $urandom_range(0, 5);
                    dm_read  = (kind <= 2 || kind == 5);
                    dm_write = (kind >= 3);
                    push_data(dm_read, dm_write, da, wd);
                    dm_addr  = da;
                    dm_wdata = wd;
                    wait_data();
                end
            end
        join
        stray_en = 1'b0;
        repeat (3) cyc_start();
        chk("end_rw_conflict", {31'h0, rw_conflict}, {31'h0, conflict_exp});
        chk("end_if_q_empty", if_q.size(), 32'h0);
        chk("end_dm_q_empty", dm_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 12, byte address width; DATA_WIDTH, 16, data word width; TIMEOUT, 15, maximum cycles mem_req waits for mem_ack.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
- if_req  in  1  instruction fetch request.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_rdata  out  DATA_WIDTH  fetched word.
- if_ready  out  1  fetch complete.
- dm_read  in  1  MEM-stage load request.
- dm_write  in  1  MEM-stage store request.
- dm_addr  in  ADDR_WIDTH  load/store address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_rdata  out  DATA_WIDTH  load data.
- dm_ready  out  1  load/store complete.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- stall_if  out  1  hold PC and IF/ID.
- stall_mem  out  1  hold the EX/MEM register and all earlier stages.
- bus_err  out  1  one-cycle timeout pulse.
- rw_conflict  out  1  sticky flag: dm_read and dm_write were high together.

Function
REQ-003 The block SHALL share one single-ported memory between the fetch port and the MEM-stage data port.
REQ-004 The FSM SHALL have three states: IDLE, DATA_BUSY and FETCH_BUSY.
REQ-005 In IDLE, a data request (dm_read|dm_write, dm_ready low) SHALL win over a fetch request (if_req, if_ready low); the state moves to DATA_BUSY or FETCH_BUSY at the next edge.
REQ-006 In IDLE, a port whose ready output is currently high SHALL be ignored, so a completed request is never re-issued.
REQ-007 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered and SHALL be latched from the granted port on entry to a busy state.
REQ-008 Those memory outputs SHALL stay constant for the whole busy state; mem_req is high throughout.
REQ-009 On mem_ack in a busy state:
- mem_rdata is captured into if_rdata or dm_rdata; dm_rdata is unchanged for a write.
- The matching ready output is high for exactly the next cycle.
- mem_req drops and the state returns to IDLE.
REQ-010 Minimum latency: request in cycle N, mem_req high from N+1, mem_ack in N+1, ready high in N+2.
REQ-011 stall_if SHALL equal if_req & ~if_ready; stall_mem SHALL equal (dm_read|dm_write) & ~dm_ready. Both are combinational.
REQ-012 Requesters SHALL hold request, address and data stable until their ready output; the arbiter does not check this.
REQ-013 If dm_read and dm_write are both high, the access SHALL be a write and rw_conflict SHALL be set until reset.
REQ-014 A counter SHALL count busy cycles without mem_ack, starting at 0 on entry to a busy state.
REQ-015 If TIMEOUT cycles pass without mem_ack:
- mem_req drops and the state returns to IDLE.
- The matching ready output is high for one cycle, with read data forced to 0.
- bus_err pulses high in that same cycle.
REQ-016 mem_ack arriving in the final timeout cycle SHALL take precedence; the access completes normally with no bus_err.
REQ-017 mem_ack in IDLE SHALL be ignored.
REQ-018 A request arriving while the other port is busy SHALL wait, with its stall output high, until it is granted.

Reset
REQ-019 Asserting reset SHALL immediately force the state to IDLE and clear the counter.
REQ-020 Asserting reset SHALL immediately clear every registered output to 0: mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_ready, dm_ready, bus_err and rw_conflict.
REQ-021 Reset mid-transaction SHALL abandon the access without a ready pulse; stall outputs follow REQ-011 once reset deasserts.

Structure
REQ-022 The state encoding (IDLE=2'd0, DATA_BUSY=2'd1, FETCH_BUSY=2'd2) and the default width constants SHALL live in a shared package (cpu_pkg), reused by the pipeline registers.
REQ-023 The timeout counter SHALL be the sub-module arb_timeout_cnt (inputs clear and enable; output expired); all other logic stays in mem_arbiter.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Fetch only: if_req=1 at 0x010 in cycle 0, mem_ack with 0xBEEF in cycle 1 -> mem_req high in cycle 1, if_ready=1 and if_rdata=0xBEEF in cycle 2, stall_if=1 in cycles 0-1.
- Contention: if_req and dm_read at 0x020 in the same cycle, ack latency 2 -> data served first, then fetch; stall_if stays high until if_ready.
- Store: dm_write, dm_addr=0x034, dm_wdata=0x1234 -> mem_we=1 with those values held until ack; dm_ready pulses once; dm_rdata unchanged.
- Timeout: dm_read with no ack, TIMEOUT=15 -> after 15 busy cycles, dm_ready=1, dm_rdata=0 and bus_err=1 in the same single cycle; then IDLE.
- Ack on the last timeout cycle -> normal completion, bus_err stays 0.
- Reset asserted in the middle of FETCH_BUSY -> all outputs 0 immediately and no if_ready pulse; rw_conflict, set earlier by dm_read=dm_write=1, is cleared.
